// File: rtl/fsm_rr_arbiter.sv
// Four-agent round-robin arbiter with a bounded hold timer.
//
// Shares one downstream resource between agents 0..3. A grant is held while its
// owner keeps req high. If the owner has held for HOLD_MAX consecutive cycles and
// another agent is waiting, the grant is forced off with a one-cycle preempt pulse.
// Every release is followed by one idle cycle before the next grant. All outputs
// are registered.
//
// Parameters:
//   HOLD_MAX  max consecutive granted cycles before forced release (0 disables)
//   CNT_W     hold counter width, HOLD_MAX <= 2**CNT_W
//
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   arb_en   1 allows new grants; an active grant is unaffected
//   req      per-agent request, bit i = agent i
//   gnt      one-hot grant, zero when idle
//   gnt_id   index of granted agent, 0 when idle
//   busy     1 while a grant is active
//   preempt  one-cycle pulse in the cycle gnt drops because of timeout

module fsm_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       arb_en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01
    } state_e;

    // Saturation value of the hold counter. With preemption disabled the counter
    // simply saturates at all-ones; its value is then never consulted.
    localparam logic [CNT_W-1:0] HoldLast =
        (HOLD_MAX == 0) ? {CNT_W{1'b1}} : CNT_W'(HOLD_MAX - 1);

    state_e           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       gnt_id_q;
    logic             busy_q;
    logic             preempt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [1:0]       last_q;

    logic [1:0] winner;
    logic       found;
    logic [1:0] cand;
    logic       others_waiting;
    logic       timeout;

    // Rotating search starting just after the last owner; the last owner itself is
    // examined last, so it has lowest priority.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        cand   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        others_waiting = (req & ~gnt_q) != 4'b0000;
        timeout        = (HOLD_MAX != 0) && (hold_cnt_q == HoldLast) && others_waiting;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            gnt_q      <= 4'b0000;
            gnt_id_q   <= 2'd0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= 2'd3;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (arb_en && found) begin
                        state_q    <= StGrant;
                        gnt_q      <= 4'b0001 << winner;
                        gnt_id_q   <= winner;
                        busy_q     <= 1'b1;
                        last_q     <= winner;
                        hold_cnt_q <= '0;
                    end else begin
                        gnt_q    <= 4'b0000;
                        gnt_id_q <= 2'd0;
                        busy_q   <= 1'b0;
                    end
                end
                StGrant: begin
                    if (!req[gnt_id_q]) begin
                        // Normal release wins over a coincident timeout.
                        state_q  <= StIdle;
                        gnt_q    <= 4'b0000;
                        gnt_id_q <= 2'd0;
                        busy_q   <= 1'b0;
                    end else if (timeout) begin
                        state_q   <= StIdle;
                        gnt_q     <= 4'b0000;
                        gnt_id_q  <= 2'd0;
                        busy_q    <= 1'b0;
                        preempt_q <= 1'b1;
                    end else if (hold_cnt_q != HoldLast) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    gnt_q    <= 4'b0000;
                    gnt_id_q <= 2'd0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: doc/fsm_rr_arbiter.md
Name: fsm_rr_arbiter

Overview:
- Four-agent round-robin arbiter that shares one downstream resource between requesters 0..3.
- Fairness is round-robin; a grant is held for as long as the owner keeps its request high.
- A bounded hold timer forces the owner off when other agents are waiting.
- Sits between the agent request lines and the shared resource's select/enable; all outputs are registered.

Parameters:
- HOLD_MAX, 8: max consecutive granted cycles before forced release when others are pending; 0 disables preemption.
- CNT_W, 4: hold counter width; HOLD_MAX <= 2**CNT_W is required.

Ports:
- clock  input  1  single clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- arb_en  input  1  1 = new grants may be issued; 0 = no new grant (current grant continues)
- req  input  4  active-high request, bit i = agent i
- gnt  output  4  registered one-hot grant, all-zero when idle
- gnt_id  output  2  index of granted agent; 0 when idle
- busy  output  1  1 while any grant is active (equals |gnt)
- preempt  output  1  one-cycle pulse, asserted in the cycle gnt drops because of timeout

Behaviour:
- Reset is synchronous, active-low:
  - reset_n=0 at a rising edge sets state=IDLE, gnt=0, gnt_id=0, busy=0, preempt=0, hold_cnt=0, last=3.
  - With last=3 reset, agent 0 has first priority.
  - Reset mid-grant drops gnt on that edge, with no preempt pulse.
- States: IDLE, GRANT.
- IDLE:
  - If arb_en=1 and req!=0, pick the first set req bit searching last+1, last+2, ... (mod 4).
  - Next edge: state=GRANT, gnt=onehot(winner), gnt_id=winner, last=winner, hold_cnt=0.
  - Otherwise remain IDLE with outputs 0.
- Latency: req sampled at edge N, gnt visible after edge N (one register stage). Grant is never issued combinationally.
- GRANT, evaluated each edge with owner = gnt_id:
  - req[owner]=0: next state IDLE, gnt=0, preempt=0. Normal release takes priority over timeout.
  - Else if HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1 and (req & ~onehot(owner))!=0: next state IDLE, gnt=0, preempt=1 for one cycle.
  - Else stay GRANT. hold_cnt increments, saturating at HOLD_MAX-1. The owner may hold indefinitely if no one else is waiting.
- Turnaround: every release (normal or preempt) is followed by exactly one IDLE cycle with gnt=0 before the next grant. Back-to-back grants without a gap never occur.
- Round-robin: the agent just released (including a preempted one) has lowest priority at the next arbitration.
- arb_en=0 does not affect an active grant. It only blocks the IDLE->GRANT transition. Requests are not latched; req must be held.
- Requests changing in IDLE are only sampled at the edge.
- Simultaneous requests are resolved solely by pointer order, never by index.
- gnt is always one-hot or zero. busy==|gnt. gnt_id matches gnt whenever busy=1.
- preempt is never high while gnt!=0 after the same edge, and never high two consecutive cycles.
- Out-of-range state (not IDLE/GRANT) returns to IDLE on the next edge with gnt=0.

Test Plan:
- Reset: hold reset_n=0 two edges with req=4'b1111 -> gnt=0, busy=0, preempt=0. Release reset -> first grant gnt=4'b0001, one edge later.
- Round-robin: req=4'b1111 held, each owner drops its req for one cycle after 3 granted cycles -> grant order 0,1,2,3,0 with exactly one gnt=0 cycle between grants.
- Timeout: HOLD_MAX=8, agent 2 holds req, agent 0 raises req at cycle 1 of grant -> gnt=4'b0100 for exactly 8 cycles, then preempt=1 with gnt=0 for one cycle, then gnt=4'b0001.
- No contention: agent 1 alone holds req for 40 cycles -> gnt=4'b0010 continuously, preempt never asserts, hold_cnt saturates at 7.
- Enable gating: arb_en=0, req=4'b1000 -> gnt stays 0. arb_en 0->1 -> gnt=4'b1000 after next edge. Dropping arb_en during that grant does not remove it.
- Mid-operation reset: reset_n=0 for one edge during a grant to agent 3 -> gnt=0 after that edge, preempt=0. The next arbitration with req=4'b1001 grants agent 0 (pointer back at 3).
